// File: rtl/layer_result_pingpong_mem.sv
// rtl/layer_result_pingpong_mem.sv - double-buffered (row,col) result store for one CNN layer
// Producer fills wr_bank while consumer reads rd_bank; frame_done/read_done hand banks across.
module layer_result_pingpong_mem #(
    parameter int DATA_W   = 128,
    parameter int ROWS     = 12,
    parameter int COLS     = 12,
    parameter int ADDR_W   = 16,
    parameter bit PINGPONG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_enable,
    input  logic [ADDR_W-1:0] save_row_addr,
    input  logic [ADDR_W-1:0] save_col_addr,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic              frame_done,
    output logic              wr_ready,
    input  logic              read_signal,
    input  logic [ADDR_W-1:0] read_row_addr,
    input  logic [ADDR_W-1:0] read_col_addr,
    input  logic              read_done,
    output logic              rd_frame_valid,
    output logic [DATA_W-1:0] result_output,
    output logic              result_valid,
    output logic              err_overflow,
    output logic              err_range
);

    localparam int DEPTH     = ROWS * COLS;
    localparam int NB        = PINGPONG ? 2 : 1;
    localparam int MEM_DEPTH = NB * DEPTH;
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LIN_W     = 2 * ADDR_W + 1;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              valid_q, valid_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_rng_q, err_rng_d;

    logic              wr_in_range, rd_in_range;
    logic              wr_en, rd_en;
    logic [LIN_W-1:0]  wr_lin, rd_lin;
    logic [MEM_AW-1:0] wr_mem_addr, rd_mem_addr;

    // Linear address kept wide enough that row*COLS+col never wraps.
    assign wr_lin = LIN_W'(save_row_addr) * LIN_W'(COLS) + LIN_W'(save_col_addr);
    assign rd_lin = LIN_W'(read_row_addr) * LIN_W'(COLS) + LIN_W'(read_col_addr);

    assign wr_in_range = (LIN_W'(save_row_addr) < LIN_W'(ROWS)) &&
                         (LIN_W'(save_col_addr) < LIN_W'(COLS));
    assign rd_in_range = (LIN_W'(read_row_addr) < LIN_W'(ROWS)) &&
                         (LIN_W'(read_col_addr) < LIN_W'(COLS));

    // Bank 1 occupies the upper half of the flat array.
    assign wr_mem_addr = MEM_AW'(wr_lin) + ((PINGPONG && wr_bank_q) ? MEM_AW'(DEPTH) : '0);
    assign rd_mem_addr = MEM_AW'(rd_lin) + ((PINGPONG && rd_bank_q) ? MEM_AW'(DEPTH) : '0);

    assign wr_ready       = PINGPONG ? !full_q[wr_bank_q] : 1'b1;
    assign rd_frame_valid = PINGPONG ?  full_q[rd_bank_q] : 1'b1;

    assign wr_en = save_enable && wr_ready && wr_in_range;
    assign rd_en = read_signal && rd_frame_valid && rd_in_range;

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        err_ovf_d = err_ovf_q;
        err_rng_d = err_rng_q;
        result_d  = rd_en ? mem[rd_mem_addr] : '0;
        valid_d   = rd_en;

        if ((save_enable && !wr_in_range) || (read_signal && !rd_in_range)) begin
            err_rng_d = 1'b1;
        end
        if (save_enable && !wr_ready) begin
            err_ovf_d = 1'b1;
        end

        // Both handshakes decide from pre-edge state, so a freed bank is writable only next cycle.
        if (PINGPONG) begin
            if (frame_done) begin
                if (wr_ready) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = !wr_bank_q;
                end else begin
                    err_ovf_d = 1'b1;
                end
            end
            if (read_done && rd_frame_valid) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            result_q  <= '0;
            valid_q   <= 1'b0;
            err_ovf_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            err_ovf_q <= err_ovf_d;
            err_rng_q <= err_rng_d;
        end
    end

    // Contents survive reset; a same-edge read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_mem_addr] <= store_data_in;
        end
    end

    assign result_output = result_q;
    assign result_valid  = valid_q;
    assign err_overflow  = err_ovf_q;
    assign err_range     = err_rng_q;

endmodule

// File: tb/tb_layer_result_pingpong_mem.sv
// tb/tb_layer_result_pingpong_mem.sv - randomized and directed checks against a frame-level model
module tb_layer_result_pingpong_mem;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         se = 0, fd = 0, rs = 0, rdn = 0;
    logic [15:0]  sr = 0, sc = 0, rr = 0, rc = 0;
    logic [127:0] sd = '0;
    logic         wr_ready, rd_fv, res_valid, err_ovf, err_rng;
    logic [127:0] res;

    logic         se2 = 0, fd2 = 0, rs2 = 0, rdn2 = 0;
    logic [15:0]  sr2 = 0, sc2 = 0, rr2 = 0, rc2 = 0;
    logic [127:0] sd2 = '0;
    logic         wr_ready2, rd_fv2, res_valid2, err_ovf2, err_rng2;
    logic [127:0] res2;

    int nvec = 0;
    int nfail = 0;

    logic [127:0] m_mem [2][144];
    bit           m_known [2][144];
    bit   [1:0]   m_full;
    bit           m_wb, m_rb, m_ovf, m_rng, m_val, m_res_known;
    logic [127:0] m_res;

    always #5 clk = ~clk;

    layer_result_pingpong_mem #(.PINGPONG(1'b1)) dut (
        .clk(clk), .rst(rst),
        .save_enable(se), .save_row_addr(sr), .save_col_addr(sc), .store_data_in(sd),
        .frame_done(fd), .wr_ready(wr_ready),
        .read_signal(rs), .read_row_addr(rr), .read_col_addr(rc), .read_done(rdn),
        .rd_frame_valid(rd_fv), .result_output(res), .result_valid(res_valid),
        .err_overflow(err_ovf), .err_range(err_rng)
    );

    layer_result_pingpong_mem #(.PINGPONG(1'b0)) dut_single (
        .clk(clk), .rst(rst),
        .save_enable(se2), .save_row_addr(sr2), .save_col_addr(sc2), .store_data_in(sd2),
        .frame_done(fd2), .wr_ready(wr_ready2),
        .read_signal(rs2), .read_row_addr(rr2), .read_col_addr(rc2), .read_done(rdn2),
        .rd_frame_valid(rd_fv2), .result_output(res2), .result_valid(res_valid2),
        .err_overflow(err_ovf2), .err_range(err_rng2)
    );

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle();
        se = 0; fd = 0; rs = 0; rdn = 0;
        se2 = 0; fd2 = 0; rs2 = 0; rdn2 = 0;
    endtask

    task automatic model_reset();
        m_full = 2'b00; m_wb = 0; m_rb = 0; m_ovf = 0; m_rng = 0;
        m_val = 0; m_res = '0; m_res_known = 1;
    endtask

    // Advance one clock; the model applies the frame-handshake rules to the pre-edge picture.
    task automatic tick();
        bit wr_rdy, rd_ok, w_in, r_in, wb0, rb0;
        int wl, rl;
        wb0 = m_wb; rb0 = m_rb;
        wr_rdy = !m_full[wb0];
        rd_ok  = m_full[rb0];
        w_in = (sr < 12) && (sc < 12);
        r_in = (rr < 12) && (rc < 12);
        wl = w_in ? int'(sr) * 12 + int'(sc) : 0;
        rl = r_in ? int'(rr) * 12 + int'(rc) : 0;
        if (rs && rd_ok && r_in) begin
            m_val = 1; m_res = m_mem[rb0][rl]; m_res_known = m_known[rb0][rl];
        end else begin
            m_val = 0; m_res = '0; m_res_known = 1;
        end
        if (rs && !r_in) m_rng = 1;
        if (se) begin
            if (!wr_rdy) m_ovf = 1;
            if (!w_in) m_rng = 1;
            if (wr_rdy && w_in) begin
                m_mem[wb0][wl] = sd; m_known[wb0][wl] = 1;
            end
        end
        if (fd) begin
            if (wr_rdy) begin m_full[wb0] = 1; m_wb = !wb0; end
            else m_ovf = 1;
        end
        if (rdn && rd_ok) begin m_full[rb0] = 0; m_rb = !rb0; end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (wr_ready !== 1'b1) begin nfail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        nvec++; if (rd_fv !== 1'b0) begin nfail++; $display("FAIL reset_rd_frame_valid: got %b want 0", rd_fv); end
        nvec++; if (res !== '0) begin nfail++; $display("FAIL reset_result: got %h want 0", res); end
        nvec++; if (res_valid !== 1'b0) begin nfail++; $display("FAIL reset_result_valid: got %b want 0", res_valid); end
        nvec++; if (err_ovf !== 1'b0) begin nfail++; $display("FAIL reset_err_overflow: got %b want 0", err_ovf); end
        nvec++; if (err_rng !== 1'b0) begin nfail++; $display("FAIL reset_err_range: got %b want 0", err_rng); end
    endtask

    task automatic test_fill_and_read();
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 12; c++) begin
                se = 1; sr = 16'(r); sc = 16'(c); sd = 128'(r * 12 + c);
                tick();
            end
        end
        se = 0;
        nvec++; if (rd_fv !== 1'b0) begin nfail++; $display("FAIL fill_not_yet_valid: got %b want 0", rd_fv); end
        fd = 1; tick(); fd = 0;
        nvec++; if (rd_fv !== 1'b1) begin nfail++; $display("FAIL fill_frame_valid: got %b want 1", rd_fv); end
        nvec++; if (wr_ready !== 1'b1) begin nfail++; $display("FAIL fill_bank1_free: got %b want 1", wr_ready); end
        rs = 1; rr = 3; rc = 5; tick(); rs = 0;
        nvec++; if (res !== 128'd41) begin nfail++; $display("FAIL read_3_5: got %h want %h", res, 128'd41); end
        nvec++; if (res_valid !== 1'b1) begin nfail++; $display("FAIL read_3_5_valid: got %b want 1", res_valid); end
        tick();
        nvec++; if (res !== '0 || res_valid !== 1'b0) begin nfail++; $display("FAIL read_drop_after: got %h/%b want 0/0", res, res_valid); end
        nvec++; if (err_rng !== 1'b0 || err_ovf !== 1'b0) begin nfail++; $display("FAIL fill_no_errors: got %b%b want 00", err_ovf, err_rng); end
    endtask

    task automatic test_read_during_write();
        se = 1; sr = 0; sc = 0; sd = {16{8'hAA}};
        rs = 1; rr = 0; rc = 0;
        tick(); idle();
        nvec++; if (res !== '0 || res_valid !== 1'b1) begin nfail++; $display("FAIL rdw_bank0_read: got %h/%b want 0/1", res, res_valid); end
        rs = 1; rr = 0; rc = 0; tick(); rs = 0;
        nvec++; if (res !== '0 || res_valid !== 1'b1) begin nfail++; $display("FAIL rdw_bank0_intact: got %h/%b want 0/1", res, res_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i < 144; i++) begin
            se = 1; sr = 16'(i / 12); sc = 16'(i % 12); sd = rand128();
            tick();
        end
        se = 0; fd = 1; tick(); fd = 0;
        nvec++; if (wr_ready !== 1'b0) begin nfail++; $display("FAIL both_full_wr_ready: got %b want 0", wr_ready); end
        nvec++; if (err_ovf !== 1'b0) begin nfail++; $display("FAIL ovf_before: got %b want 0", err_ovf); end
        se = 1; sr = 1; sc = 1; sd = rand128(); fd = 1; tick(); idle();
        nvec++; if (err_ovf !== 1'b1) begin nfail++; $display("FAIL ovf_set: got %b want 1", err_ovf); end
        nvec++; if (wr_ready !== 1'b0 || rd_fv !== 1'b1) begin nfail++; $display("FAIL ovf_state: got %b/%b want 0/1", wr_ready, rd_fv); end
        rs = 1; rr = 1; rc = 1; tick(); rs = 0;
        nvec++; if (res !== 128'd13) begin nfail++; $display("FAIL ovf_bank0_intact: got %h want %h", res, 128'd13); end
        nvec++; if (err_ovf !== 1'b1) begin nfail++; $display("FAIL ovf_sticky: got %b want 1", err_ovf); end
    endtask

    task automatic test_range();
        rs = 1; rr = 12; rc = 0; se = 1; sr = 0; sc = 12; sd = rand128();
        tick(); idle();
        nvec++; if (res !== '0 || res_valid !== 1'b0) begin nfail++; $display("FAIL range_read: got %h/%b want 0/0", res, res_valid); end
        nvec++; if (err_rng !== 1'b1) begin nfail++; $display("FAIL range_err: got %b want 1", err_rng); end
        rs = 1; rr = 0; rc = 11; tick(); rs = 0;
        nvec++; if (res !== 128'd11 || res_valid !== 1'b1) begin nfail++; $display("FAIL range_no_change: got %h/%b want b/1", res, res_valid); end
    endtask

    task automatic test_simultaneous();
        rdn = 1; tick(); rdn = 0;
        nvec++; if (wr_ready !== 1'b1 || rd_fv !== 1'b1) begin nfail++; $display("FAIL release_bank0: got %b/%b want 1/1", wr_ready, rd_fv); end
        fd = 1; rdn = 1; tick(); idle();
        nvec++; if (wr_ready !== 1'b1 || rd_fv !== 1'b1) begin nfail++; $display("FAIL sim_handshake: got %b/%b want 1/1", wr_ready, rd_fv); end
        rs = 1; rr = 3; rc = 5; tick(); rs = 0;
        nvec++; if (res !== 128'd41 || res_valid !== 1'b1) begin nfail++; $display("FAIL sim_rd_bank0: got %h/%b want 29/1", res, res_valid); end
        rdn = 1; tick(); rdn = 0;
        nvec++; if (rd_fv !== 1'b0 || wr_ready !== 1'b1) begin nfail++; $display("FAIL sim_drained: got %b/%b want 0/1", rd_fv, wr_ready); end
        rdn = 1; tick(); rdn = 0;
        nvec++; if (rd_fv !== 1'b0 || err_ovf !== m_ovf) begin nfail++; $display("FAIL empty_read_done: got %b/%b want 0/%b", rd_fv, err_ovf, m_ovf); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            se  = ($urandom_range(0, 1) == 1);
            sr  = 16'($urandom_range(0, 12)); sc = 16'($urandom_range(0, 12));
            sd  = rand128();
            fd  = ($urandom_range(0, 19) == 0);
            rdn = ($urandom_range(0, 19) == 0);
            rs  = ($urandom_range(0, 1) == 1);
            rr  = 16'($urandom_range(0, 12)); rc = 16'($urandom_range(0, 12));
            tick();
            nvec++; if (wr_ready !== !m_full[m_wb]) begin nfail++; $display("FAIL rnd_wr_ready[%0d]: got %b want %b", n, wr_ready, !m_full[m_wb]); end
            nvec++; if (rd_fv !== m_full[m_rb]) begin nfail++; $display("FAIL rnd_frame_valid[%0d]: got %b want %b", n, rd_fv, m_full[m_rb]); end
            nvec++; if (res_valid !== m_val) begin nfail++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, res_valid, m_val); end
            if (m_res_known) begin
                nvec++; if (res !== m_res) begin nfail++; $display("FAIL rnd_result[%0d]: got %h want %h", n, res, m_res); end
            end
            nvec++; if (err_ovf !== m_ovf || err_rng !== m_rng) begin nfail++; $display("FAIL rnd_errs[%0d]: got %b%b want %b%b", n, err_ovf, err_rng, m_ovf, m_rng); end
        end
        idle();
    endtask

    task automatic test_reset_midfill();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            se = 1; sr = 16'(i / 12); sc = 16'(i % 12); sd = rand128();
            tick();
        end
        #2 rst = 0;
        idle(); model_reset();
        @(posedge clk); #1;
        nvec++; if (res_valid !== 1'b0 || wr_ready !== 1'b1) begin nfail++; $display("FAIL in_reset: got %b/%b want 0/1", res_valid, wr_ready); end
        rst = 1;
        tick();
        nvec++; if (wr_ready !== 1'b1 || rd_fv !== 1'b0) begin nfail++; $display("FAIL midreset_empty: got %b/%b want 1/0", wr_ready, rd_fv); end
        nvec++; if (res !== '0 || res_valid !== 1'b0 || err_ovf !== 1'b0 || err_rng !== 1'b0) begin nfail++; $display("FAIL midreset_outputs: got %h/%b/%b/%b want 0", res, res_valid, err_ovf, err_rng); end
        rs = 1; rr = 0; rc = 0; tick(); rs = 0;
        nvec++; if (res_valid !== 1'b0) begin nfail++; $display("FAIL midreset_no_frame: got %b want 0", res_valid); end
    endtask

    task automatic test_single_bank();
        logic [127:0] old_v, new_v;
        old_v = rand128(); new_v = rand128();
        nvec++; if (wr_ready2 !== 1'b1 || rd_fv2 !== 1'b1) begin nfail++; $display("FAIL single_flags: got %b/%b want 1/1", wr_ready2, rd_fv2); end
        se2 = 1; sr2 = 2; sc2 = 3; sd2 = old_v; tick();
        se2 = 1; sd2 = new_v; rs2 = 1; rr2 = 2; rc2 = 3; tick(); se2 = 0;
        nvec++; if (res2 !== old_v || res_valid2 !== 1'b1) begin nfail++; $display("FAIL single_rdw_old: got %h/%b want %h/1", res2, res_valid2, old_v); end
        tick(); rs2 = 0;
        nvec++; if (res2 !== new_v) begin nfail++; $display("FAIL single_new: got %h want %h", res2, new_v); end
        fd2 = 1; rdn2 = 1; se2 = 1; sr2 = 0; sc2 = 0; sd2 = new_v; tick();
        fd2 = 1; tick(); idle();
        nvec++; if (wr_ready2 !== 1'b1 || rd_fv2 !== 1'b1 || err_ovf2 !== 1'b0) begin nfail++; $display("FAIL single_handshake_ignored: got %b/%b/%b want 1/1/0", wr_ready2, rd_fv2, err_ovf2); end
        rs2 = 1; rr2 = 0; rc2 = 0; tick(); rs2 = 0;
        nvec++; if (res2 !== new_v || res_valid2 !== 1'b1) begin nfail++; $display("FAIL single_after_pulses: got %h/%b want %h/1", res2, res_valid2, new_v); end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 144; i++) m_known[b][i] = 0;
        test_reset();
        test_fill_and_read();
        test_read_during_write();
        test_overflow();
        test_range();
        test_simultaneous();
        test_random();
        test_reset_midfill();
        test_single_bank();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
